// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24 h HH:MM:SS timekeeper with NUM_ALARMS HH:MM alarms and a
// ring/snooze controller.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no alarm active; alarm matches are evaluated on sec_tick
//   ST_RING   | ringing for ring_id; auto-stops after RING_SEC seconds
//   ST_SNOOZE | silenced for ring_id; re-rings after SNOOZE_MIN minutes
module alarm_clock_core #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [2:0]            set_tgt,
  input  logic                  set_fld,
  input  logic                  inc,
  input  logic [NUM_ALARMS-1:0] alarm_arm,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_bcd,
  output logic                  sec_tick,
  output logic                  ringing,
  output logic [1:0]            ring_id,
  output logic                  alarm_hit
);

  localparam int              PW          = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [15:0]     RING_LIM    = 16'(RING_SEC);
  localparam logic [15:0]     SNOOZE_LIM  = 16'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic [4:0]    al_hh_q [NUM_ALARMS];
  logic [5:0]    al_mm_q [NUM_ALARMS];

  state_t        state_q, state_d;
  logic [15:0]   sec_cnt_q, sec_cnt_d, sec_cnt_inc;
  logic [1:0]    ring_id_d;
  logic          ringing_d, alarm_hit_d;

  logic          setting_time;
  logic          tick;
  logic          match_any;
  logic [1:0]    match_idx;
  logic          arm_sel;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // While the clock itself is being set the second counter is frozen, so no tick.
  assign setting_time = set_en && (set_tgt == 3'd0);
  assign tick         = (presc_q == PRESC_MAX) && !setting_time;
  assign sec_tick     = tick;
  assign sec_cnt_inc  = sec_cnt_q + 16'd1;

  // Next time value: either a field edit (fields wrap independently) or the one-second advance.
  always_comb begin
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    if (setting_time) begin
      presc_d = '0;
      ss_d    = '0;
      if (inc) begin
        if (set_fld) hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        else         mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
      end
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (ss_q == 6'd59) begin
          ss_d = '0;
          if (mm_q == 6'd59) begin
            mm_d = '0;
            hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
          end else begin
            mm_d = mm_q + 6'd1;
          end
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end
    end
  end

  // Time registers plus the registered BCD view of the current time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
      time_bcd <= '0;
    end else begin
      presc_q  <= presc_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      time_bcd <= {to_bcd({1'b0, hh_q}), to_bcd(mm_q), to_bcd(ss_q)};
    end
  end

  // Alarm set-points, edited field by field while their target is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hh_q[i] <= '0;
        al_mm_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (set_en && inc && (set_tgt == 3'(i + 1))) begin
          if (set_fld) al_hh_q[i] <= (al_hh_q[i] == 5'd23) ? 5'd0 : al_hh_q[i] + 5'd1;
          else         al_mm_q[i] <= (al_mm_q[i] == 6'd59) ? 6'd0 : al_mm_q[i] + 6'd1;
        end
      end
    end
  end

  // Alarm match against the time this tick lands on; descending scan so the lowest index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (tick && alarm_arm[i] && (ss_d == 6'd0) &&
          (mm_d == al_mm_q[i]) && (hh_d == al_hh_q[i])) begin
        match_any = 1'b1;
        match_idx = 2'(i);
      end
    end
  end

  // Arm level of the channel that owns the current ring/snooze.
  always_comb begin
    arm_sel = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (ring_id == 2'(i)) arm_sel = alarm_arm[i];
    end
  end

  // FSM state register and its registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sec_cnt_q <= '0;
      ring_id   <= '0;
      ringing   <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      ring_id   <= ring_id_d;
      ringing   <= ringing_d;
      alarm_hit <= alarm_hit_d;
    end
  end

  // Next state: dismiss beats snooze, disarm beats timeouts, other-channel matches are dropped.
  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    ring_id_d = ring_id;
    case (state_q)
      ST_IDLE: begin
        if (match_any) begin
          state_d   = ST_RING;
          sec_cnt_d = '0;
          ring_id_d = match_idx;
        end
      end
      ST_RING: begin
        if (dismiss || !arm_sel) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          sec_cnt_d = '0;
        end else if (tick) begin
          if (sec_cnt_inc >= RING_LIM) state_d = ST_IDLE;
          else                         sec_cnt_d = sec_cnt_inc;
        end
      end
      ST_SNOOZE: begin
        if (dismiss || !arm_sel) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sec_cnt_inc >= SNOOZE_LIM) begin
            state_d   = ST_RING;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = sec_cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ringing follows RING; alarm_hit marks every entry into RING.
  always_comb begin
    ringing_d   = (state_d == ST_RING);
    alarm_hit_d = (state_d == ST_RING) && (state_q != ST_RING);
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Testbench for alarm_clock_core: per-cycle scoreboard fed by a seconds-of-day reference model.
module tb_alarm_clock_core;

  localparam int TD = 4;
  localparam int NA = 2;
  localparam int SM = 1;
  localparam int RS = 3;

  logic          clk;
  logic          reset_n;
  logic          set_en;
  logic [2:0]    set_tgt;
  logic          set_fld;
  logic          inc;
  logic [NA-1:0] alarm_arm;
  logic          snooze;
  logic          dismiss;
  logic [23:0]   time_bcd;
  logic          sec_tick;
  logic          ringing;
  logic [1:0]    ring_id;
  logic          alarm_hit;

  alarm_clock_core #(.TICK_DIV(TD), .NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut (
    .clk(clk), .reset_n(reset_n), .set_en(set_en), .set_tgt(set_tgt), .set_fld(set_fld),
    .inc(inc), .alarm_arm(alarm_arm), .snooze(snooze), .dismiss(dismiss),
    .time_bcd(time_bcd), .sec_tick(sec_tick), .ringing(ringing), .ring_id(ring_id),
    .alarm_hit(alarm_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tb;
    logic        st;
    logic        rg;
    logic [1:0]  id;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: time as seconds-of-day, alarms as minutes-of-day, ring/snooze as countdowns.
  int m_presc, m_tod, m_left, m_id;
  int m_al[NA];
  bit m_ring, m_snz;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [23:0] bcd_of(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_presc = 0; m_tod = 0; m_left = 0; m_id = 0;
    m_ring = 0; m_snz = 0;
    for (int i = 0; i < NA; i++) m_al[i] = 0;
  endtask

  // Monitor: every sampled cycle is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("time_bcd",  time_bcd,  e.tb);
      chk("sec_tick",  sec_tick,  e.st);
      chk("ringing",   ringing,   e.rg);
      chk("ring_id",   ring_id,   e.id);
      chk("alarm_hit", alarm_hit, e.hit);
    end
  end

  // Advance the model across the coming clock edge, queue its outputs, then let the edge happen.
  task automatic step();
    exp_t e;
    bit   setting, tick, hit, found;
    int   h, mi, tnew, k;
    setting = set_en && (set_tgt == 3'd0);
    tick    = (m_presc == TD - 1) && !setting;
    e.tb    = bcd_of(m_tod);
    if (setting) begin
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      if (inc) begin
        if (set_fld) h = (h + 1) % 24;
        else         mi = (mi + 1) % 60;
      end
      tnew    = h * 3600 + mi * 60;
      m_presc = 0;
    end else begin
      m_presc = tick ? 0 : m_presc + 1;
      tnew    = tick ? (m_tod + 1) % 86400 : m_tod;
    end
    hit = 0;
    if (m_ring) begin
      if (dismiss || !alarm_arm[m_id]) m_ring = 0;
      else if (snooze) begin m_ring = 0; m_snz = 1; m_left = SM * 60; end
      else if (tick) begin
        m_left--;
        if (m_left == 0) m_ring = 0;
      end
    end else if (m_snz) begin
      if (dismiss || !alarm_arm[m_id]) m_snz = 0;
      else if (tick) begin
        m_left--;
        if (m_left == 0) begin m_snz = 0; m_ring = 1; m_left = RS; hit = 1; end
      end
    end else if (tick && (tnew % 60 == 0)) begin
      found = 0;
      for (int i = 0; i < NA; i++) begin
        if (!found && alarm_arm[i] && (m_al[i] == tnew / 60)) begin
          found = 1; m_ring = 1; m_left = RS; m_id = i; hit = 1;
        end
      end
    end
    if (set_en && inc && (set_tgt >= 3'd1) && (int'(set_tgt) <= NA)) begin
      k  = int'(set_tgt) - 1;
      h  = m_al[k] / 60;
      mi = m_al[k] % 60;
      if (set_fld) h = (h + 1) % 24;
      else         mi = (mi + 1) % 60;
      m_al[k] = h * 60 + mi;
    end
    m_tod = tnew;
    e.st  = (m_presc == TD - 1) && !setting;
    e.rg  = m_ring;
    e.id  = 2'(m_id);
    e.hit = hit;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    inc = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_inc();
    inc = 1;
    step();
    step();
  endtask

  task automatic set_time(input int h, input int m);
    set_en = 1; set_tgt = 3'd0; set_fld = 1;
    step();
    repeat ((h - m_tod / 3600 + 24) % 24) pulse_inc();
    set_fld = 0;
    repeat ((m - (m_tod / 60) % 60 + 60) % 60) pulse_inc();
    set_en = 0;
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    set_en = 1; set_tgt = 3'(k + 1); set_fld = 1;
    step();
    repeat ((h - m_al[k] / 60 + 24) % 24) pulse_inc();
    set_fld = 0;
    repeat ((m - m_al[k] % 60 + 60) % 60) pulse_inc();
    set_en = 0;
  endtask

  task automatic set_alarm_ahead(input int k, input int d);
    int t;
    t = (m_tod / 60 + d) % 1440;
    set_alarm(k, t / 60, t % 60);
  endtask

  task automatic wait_ring(input int bound);
    int n;
    n = 0;
    while (!m_ring && n < bound) begin
      step();
      n++;
    end
    chk("ring_started", ringing, 1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    chk("rst_time_bcd",  time_bcd,  0);
    chk("rst_sec_tick",  sec_tick,  0);
    chk("rst_ringing",   ringing,   0);
    chk("rst_ring_id",   ring_id,   0);
    chk("rst_alarm_hit", alarm_hit, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic run_random(input int n);
    int b;
    repeat (n) begin
      snooze  = ($urandom_range(0, 29) == 0);
      dismiss = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 149) == 0) begin
        b = $urandom_range(0, NA - 1);
        alarm_arm[b] = ~alarm_arm[b];
      end
      step();
    end
  endtask

  initial begin
    int last, rc;
    reset_n = 1; set_en = 0; set_tgt = 0; set_fld = 0; inc = 0;
    alarm_arm = '0; snooze = 0; dismiss = 0;
    model_reset();
    #1;
    do_reset();

    // 1: one minute from reset, then the tick period
    run(241);
    chk("t1_time", time_bcd, 24'h000100);
    last = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sec_tick) begin
        if (last >= 0) chk("t1_tick_period", i - last, TD);
        last = i;
      end
    end

    // 2: field wrap without carry
    do_reset();
    set_en = 1; set_tgt = 3'd0; set_fld = 1;
    step();
    repeat (25) pulse_inc();
    set_fld = 0;
    repeat (61) pulse_inc();
    step();
    chk("t2_set", time_bcd, 24'h010100);

    // 3: midnight rollover with alarms disarmed (both sit at 00:00)
    set_time(23, 59);
    run(241);
    chk("t3_wrap", time_bcd, 24'h000000);

    // 4: two alarms on the same minute, lowest wins, auto-stop after RS seconds
    set_alarm(0, 0, 1);
    set_alarm(1, 0, 1);
    alarm_arm = 2'b11;
    set_time(0, 0);
    run(236);
    rc = 0;
    repeat (30) begin
      step();
      if (ringing) begin
        rc++;
        chk("t4_ring_id", ring_id, 0);
      end
    end
    chk("t4_ring_len", rc, RS * TD);

    // 5: dismiss beats snooze; then snooze and re-ring
    set_alarm_ahead(0, 2);
    wait_ring(2000);
    snooze = 1; dismiss = 1;
    step();
    chk("t5_dismiss_wins", ringing, 0);
    set_alarm_ahead(0, 2);
    wait_ring(2000);
    snooze = 1;
    step();
    chk("t5_snoozed", ringing, 0);
    wait_ring(SM * 60 * TD + 2 * TD);
    chk("t5_rering_hit", alarm_hit, 1);

    // 6: disarm while ringing, then reset in the middle of a snooze on channel 1
    alarm_arm[0] = 0;
    step();
    chk("t6_disarm", ringing, 0);
    alarm_arm = 2'b10;
    set_alarm_ahead(1, 2);
    wait_ring(2000);
    chk("t6_ring_id", ring_id, 1);
    snooze = 1;
    step();
    run(20);
    do_reset();

    // randomized traffic
    alarm_arm = 2'b11;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 9))
        0, 1: set_alarm_ahead($urandom_range(0, NA - 1), $urandom_range(1, 2));
        2: begin
          set_en = 1; set_tgt = 3'd0; set_fld = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 3)) pulse_inc();
          set_en = 0;
        end
        3: begin
          set_en = 1; set_tgt = 3'($urandom_range(3, 7)); set_fld = 1'($urandom_range(0, 1));
          repeat (3) pulse_inc();
          set_en = 0;
        end
        default: run_random($urandom_range(40, 200));
      endcase
    end
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
